// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: measures high/low pulse lengths to recover
// 24-bit pixel words, detects latch gaps and flags malformed pulses.
module ws2812_rx #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned BITS_PER_PIXEL = 24,
    parameter int unsigned PX_COUNT_WIDTH = 6,
    parameter int unsigned PX_NUM         = 52,
    parameter int unsigned MIN_HIGH       = 15,
    parameter int unsigned BIT_THRESH     = 60,
    parameter int unsigned MAX_HIGH       = 200,
    parameter int unsigned RESET_CYCLES   = 5000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    output logic [BITS_PER_PIXEL-1:0] pixel,
    output logic                      pixel_valid,
    output logic [PX_COUNT_WIDTH-1:0] px_num,
    output logic                      frame_done,
    output logic                      bit_error,
    output logic                      busy
);

    localparam int unsigned BIT_W  = $clog2(BITS_PER_PIXEL + 1);
    localparam int unsigned HIGH_W = $clog2(MAX_HIGH + 2);
    localparam int unsigned LOW_W  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned PIX_W  = PX_COUNT_WIDTH + 1;

    localparam logic [HIGH_W-1:0] HIGH_SAT   = HIGH_W'(MAX_HIGH + 1);
    localparam logic [HIGH_W-1:0] HIGH_MAX   = HIGH_W'(MAX_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_MIN   = HIGH_W'(MIN_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_ONE   = HIGH_W'(BIT_THRESH);
    localparam logic [LOW_W-1:0]  LOW_LATCH  = LOW_W'(RESET_CYCLES);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(BITS_PER_PIXEL - 1);
    localparam logic [PIX_W-1:0]  PIX_LIMIT  = PIX_W'(PX_NUM);

    // Thresholds must be ordered and the clock rate meaningful
    if (CLK_FREQ == 0 || MIN_HIGH >= BIT_THRESH || BIT_THRESH > MAX_HIGH
        || MAX_HIGH >= RESET_CYCLES) begin : g_bad_params
        $error("ws2812_rx: inconsistent timing parameters");
    end

    typedef enum logic [1:0] {
        S_SYNC,
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t                    state_q, state_d;
    logic                      sync1_q;
    logic                      din_s_q;
    logic                      din_q;
    logic [HIGH_W-1:0]         high_cnt_q, high_cnt_d;
    logic [LOW_W-1:0]          low_cnt_q, low_cnt_d;
    logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [PIX_W-1:0]          pix_cnt_q, pix_cnt_d;
    logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
    logic                      done_q, done_d;
    logic [BITS_PER_PIXEL-1:0] pixel_q, pixel_d;
    logic [PX_COUNT_WIDTH-1:0] px_num_q, px_num_d;
    logic                      pixel_valid_q, pixel_valid_d;
    logic                      frame_done_q, frame_done_d;
    logic                      bit_error_q, bit_error_d;
    logic                      busy_q, busy_d;

    logic                      rise_c;
    logic                      fall_c;
    logic                      bit_c;
    logic [HIGH_W-1:0]         high_inc_c;
    logic [LOW_W-1:0]          low_inc_c;

    assign rise_c     = din_s_q & ~din_q;
    assign fall_c     = ~din_s_q & din_q;
    assign bit_c      = (high_cnt_q >= HIGH_ONE);
    assign high_inc_c = (high_cnt_q >= HIGH_SAT) ? HIGH_SAT : high_cnt_q + HIGH_W'(1);
    assign low_inc_c  = (low_cnt_q >= LOW_LATCH) ? LOW_LATCH : low_cnt_q + LOW_W'(1);

    always_comb begin
        state_d       = state_q;
        high_cnt_d    = high_cnt_q;
        low_cnt_d     = low_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        shift_d       = shift_q;
        done_d        = 1'b0;
        pixel_d       = pixel_q;
        px_num_d      = px_num_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        bit_error_d   = 1'b0;
        busy_d        = busy_q;

        // Publish the word completed on the previous cycle, then advance the index
        if (done_q) begin
            if (pix_cnt_q < PIX_LIMIT) begin
                pixel_valid_d = 1'b1;
                pixel_d       = shift_q;
                px_num_d      = pix_cnt_q[PX_COUNT_WIDTH-1:0];
            end
            if (pix_cnt_q != '1) begin
                pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
        end

        unique case (state_q)
            S_SYNC: begin
                if (din_s_q) begin
                    low_cnt_d = '0;
                end else if (low_inc_c == LOW_LATCH) begin
                    low_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    low_cnt_d = low_inc_c;
                end
            end

            S_IDLE: begin
                if (rise_c) begin
                    high_cnt_d = HIGH_W'(1);
                    busy_d     = 1'b1;
                    state_d    = S_HIGH;
                end
            end

            S_HIGH: begin
                if (high_cnt_q > HIGH_MAX || (fall_c && high_cnt_q < HIGH_MIN)) begin
                    // Stuck line or glitch: drop the frame and resynchronise
                    bit_error_d = 1'b1;
                    busy_d      = 1'b0;
                    high_cnt_d  = '0;
                    low_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    pix_cnt_d   = '0;
                    shift_d     = '0;
                    state_d     = S_SYNC;
                end else if (fall_c) begin
                    shift_d   = {shift_q[BITS_PER_PIXEL-2:0], bit_c};
                    low_cnt_d = LOW_W'(1);
                    state_d   = S_LOW;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else if (din_s_q) begin
                    high_cnt_d = high_inc_c;
                end
            end

            S_LOW: begin
                if (rise_c) begin
                    high_cnt_d = HIGH_W'(1);
                    state_d    = S_HIGH;
                end else if (low_inc_c == LOW_LATCH) begin
                    frame_done_d = (pix_cnt_q != '0);
                    bit_error_d  = (bit_cnt_q != '0);
                    pix_cnt_d    = '0;
                    bit_cnt_d    = '0;
                    shift_d      = '0;
                    low_cnt_d    = '0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    low_cnt_d = low_inc_c;
                end
            end

            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_SYNC;
            sync1_q       <= 1'b0;
            din_s_q       <= 1'b0;
            din_q         <= 1'b0;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            shift_q       <= '0;
            done_q        <= 1'b0;
            pixel_q       <= '0;
            px_num_q      <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            bit_error_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= din;
            din_s_q       <= sync1_q;
            din_q         <= din_s_q;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            shift_q       <= shift_d;
            done_q        <= done_d;
            pixel_q       <= pixel_d;
            px_num_q      <= px_num_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            bit_error_q   <= bit_error_d;
            busy_q        <= busy_d;
        end
    end

    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;
    assign px_num      = px_num_q;
    assign frame_done  = frame_done_q;
    assign bit_error   = bit_error_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives pulse trains on din and checks the
// decoded pixels, strobes and error flags against hand-computed values.
module tb_ws2812_rx;

    // Shortened latch gap keeps the full 55-pixel frame within a small run
    localparam int unsigned RST_CYC = 800;
    localparam int unsigned GAP     = 850;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic [5:0]  px_num;
    logic        frame_done;
    logic        bit_error;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fd_cnt    = 0;
    int be_cnt    = 0;
    logic [23:0] pix_q[$];
    logic [5:0]  num_q[$];

    always #5 clk = ~clk;

    ws2812_rx #(.RESET_CYCLES(RST_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
        .px_num     (px_num),
        .frame_done (frame_done),
        .bit_error  (bit_error),
        .busy       (busy)
    );

    // Observation log sampled on the falling edge
    always @(negedge clk) begin
        if (pixel_valid) begin
            pix_q.push_back(pixel);
            num_q.push_back(px_num);
        end
        if (frame_done) fd_cnt++;
        if (bit_error)  be_cnt++;
    end

    task automatic send_level(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin send_level(1'b1, 80); send_level(1'b0, 45); end
        else   begin send_level(1'b1, 40); send_level(1'b0, 85); end
    endtask

    task automatic send_bit_fast(input logic b);
        if (b) begin send_level(1'b1, 61); send_level(1'b0, 4); end
        else   begin send_level(1'b1, 16); send_level(1'b0, 4); end
    endtask

    task automatic send_pixel_fast(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit_fast(w[i]);
    endtask

    task automatic gap();
        send_level(1'b0, GAP);
    endtask

    task automatic clear_obs();
        pix_q.delete();
        num_q.delete();
        fd_cnt = 0;
        be_cnt = 0;
    endtask

    function automatic logic [23:0] frame_px(input int i);
        logic [7:0] v;
        v = 8'(i);
        return {v, ~v, 8'hA5};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (pixel !== 24'h0) $display("FAIL reset_pixel: got %h want 000000", pixel);
        else pass_cnt++;
        total_cnt++;
        if (px_num !== 6'd0) $display("FAIL reset_px_num: got %0d want 0", px_num);
        else pass_cnt++;
        total_cnt++;
        if ({pixel_valid, frame_done, bit_error, busy} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {pixel_valid, frame_done, bit_error, busy});
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [23:0] w;
        int          lat;
        w = 24'hFF0000;
        gap();
        clear_obs();
        for (int i = 23; i >= 1; i--) begin
            send_bit(w[i]);
            if (i == 23) begin
                total_cnt++;
                if (busy !== 1'b1) $display("FAIL single_busy_high: got %b want 1", busy);
                else pass_cnt++;
            end
        end
        send_level(1'b1, 40);
        din = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (pixel_valid && lat == 0) lat = i;
        end
        gap();
        total_cnt++;
        if (lat !== 4) $display("FAIL single_latency: got %0d want 4", lat);
        else pass_cnt++;
        total_cnt++;
        if (pix_q.size() !== 1) $display("FAIL single_count: got %0d want 1", pix_q.size());
        else pass_cnt++;
        if (pix_q.size() >= 1) begin
            total_cnt++;
            if (pix_q[0] !== 24'hFF0000 || num_q[0] !== 6'd0)
                $display("FAIL single_data: got %h/%0d want ff0000/0", pix_q[0], num_q[0]);
            else pass_cnt++;
        end
        total_cnt++;
        if (pixel !== 24'hFF0000) $display("FAIL single_hold: got %h want ff0000", pixel);
        else pass_cnt++;
        total_cnt++;
        if (fd_cnt !== 1 || be_cnt !== 0)
            $display("FAIL single_flags: got fd=%0d be=%0d want fd=1 be=0", fd_cnt, be_cnt);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL single_busy_low: got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_full_frame();
        clear_obs();
        for (int p = 0; p < 55; p++) send_pixel_fast(frame_px(p));
        gap();
        total_cnt++;
        if (pix_q.size() !== 52) $display("FAIL frame_count: got %0d want 52", pix_q.size());
        else pass_cnt++;
        for (int i = 0; i < pix_q.size() && i < 52; i++) begin
            total_cnt++;
            if (num_q[i] !== 6'(i) || pix_q[i] !== frame_px(i))
                $display("FAIL frame_px%0d: got %h/%0d want %h/%0d", i, pix_q[i], num_q[i], frame_px(i), i);
            else pass_cnt++;
        end
        total_cnt++;
        if (fd_cnt !== 1 || be_cnt !== 0)
            $display("FAIL frame_flags: got fd=%0d be=%0d want fd=1 be=0", fd_cnt, be_cnt);
        else pass_cnt++;
    endtask

    task automatic test_partial();
        logic [9:0] b;
        b = 10'b1011001110;
        clear_obs();
        for (int i = 9; i >= 0; i--) send_bit(b[i]);
        gap();
        total_cnt++;
        if (pix_q.size() !== 0) $display("FAIL partial_count: got %0d want 0", pix_q.size());
        else pass_cnt++;
        total_cnt++;
        if (fd_cnt !== 0 || be_cnt !== 1)
            $display("FAIL partial_flags: got fd=%0d be=%0d want fd=0 be=1", fd_cnt, be_cnt);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL partial_busy: got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        logic [9:0] b;
        b = 10'b0110100101;
        clear_obs();
        for (int i = 9; i >= 0; i--) send_bit_fast(b[i]);
        send_level(1'b1, 5);
        send_level(1'b0, 85);
        send_pixel_fast(24'h123456);
        gap();
        total_cnt++;
        if (pix_q.size() !== 0 || fd_cnt !== 0 || be_cnt !== 1)
            $display("FAIL glitch_detect: got n=%0d fd=%0d be=%0d want n=0 fd=0 be=1",
                     pix_q.size(), fd_cnt, be_cnt);
        else pass_cnt++;
        clear_obs();
        send_pixel_fast(24'h5A5A5A);
        gap();
        total_cnt++;
        if (pix_q.size() !== 1) $display("FAIL glitch_recover_count: got %0d want 1", pix_q.size());
        else pass_cnt++;
        if (pix_q.size() >= 1) begin
            total_cnt++;
            if (pix_q[0] !== 24'h5A5A5A || num_q[0] !== 6'd0)
                $display("FAIL glitch_recover_data: got %h/%0d want 5a5a5a/0", pix_q[0], num_q[0]);
            else pass_cnt++;
        end
        total_cnt++;
        if (fd_cnt !== 1 || be_cnt !== 0)
            $display("FAIL glitch_recover_flags: got fd=%0d be=%0d want fd=1 be=0", fd_cnt, be_cnt);
        else pass_cnt++;
    endtask

    task automatic test_stuck();
        logic [23:0] w;
        w = 24'h800001;
        clear_obs();
        send_level(1'b1, 150);
        total_cnt++;
        if (be_cnt !== 0 || busy !== 1'b1)
            $display("FAIL stuck_early: got be=%0d busy=%b want be=0 busy=1", be_cnt, busy);
        else pass_cnt++;
        send_level(1'b1, 150);
        total_cnt++;
        if (be_cnt !== 1 || busy !== 1'b0)
            $display("FAIL stuck_error: got be=%0d busy=%b want be=1 busy=0", be_cnt, busy);
        else pass_cnt++;
        gap();
        total_cnt++;
        if (be_cnt !== 1 || fd_cnt !== 0)
            $display("FAIL stuck_once: got be=%0d fd=%0d want be=1 fd=0", be_cnt, fd_cnt);
        else pass_cnt++;
        // 200-cycle high is still legal and decodes as a 1
        clear_obs();
        send_level(1'b1, 200);
        send_level(1'b0, 45);
        for (int i = 22; i >= 0; i--) send_bit_fast(w[i]);
        gap();
        total_cnt++;
        if (pix_q.size() !== 1 || be_cnt !== 0)
            $display("FAIL stuck_recover: got n=%0d be=%0d want n=1 be=0", pix_q.size(), be_cnt);
        else pass_cnt++;
        if (pix_q.size() >= 1) begin
            total_cnt++;
            if (pix_q[0] !== 24'h800001)
                $display("FAIL stuck_max_high: got %h want 800001", pix_q[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] w;
        w = 24'hABCDEF;
        clear_obs();
        for (int i = 23; i >= 13; i--) send_bit_fast(w[i]);
        send_level(1'b1, 30);
        reset = 1'b1;
        send_level(1'b1, 3);
        total_cnt++;
        if (pixel !== 24'h0 || busy !== 1'b0)
            $display("FAIL midreset_clear: got %h busy=%b want 000000 busy=0", pixel, busy);
        else pass_cnt++;
        reset = 1'b0;
        send_level(1'b1, 20);
        send_level(1'b0, 4);
        for (int i = 11; i >= 0; i--) send_bit_fast(w[i]);
        send_pixel_fast(24'h111111);
        send_pixel_fast(24'h222222);
        gap();
        total_cnt++;
        if (pix_q.size() !== 0 || fd_cnt !== 0 || be_cnt !== 0)
            $display("FAIL midreset_quiet: got n=%0d fd=%0d be=%0d want 0/0/0",
                     pix_q.size(), fd_cnt, be_cnt);
        else pass_cnt++;
        clear_obs();
        send_pixel_fast(24'hC0FFEE);
        send_pixel_fast(24'h0BADF0);
        gap();
        total_cnt++;
        if (pix_q.size() !== 2 || fd_cnt !== 1)
            $display("FAIL midreset_frame: got n=%0d fd=%0d want n=2 fd=1", pix_q.size(), fd_cnt);
        else pass_cnt++;
        if (pix_q.size() >= 2) begin
            total_cnt++;
            if (pix_q[0] !== 24'hC0FFEE || num_q[0] !== 6'd0 ||
                pix_q[1] !== 24'h0BADF0 || num_q[1] !== 6'd1)
                $display("FAIL midreset_data: got %h/%0d %h/%0d want c0ffee/0 0badf0/1",
                         pix_q[0], num_q[0], pix_q[1], num_q[1]);
            else pass_cnt++;
        end
    endtask

    task automatic test_boundary();
        clear_obs();
        send_level(1'b1, 59);
        send_level(1'b0, 85);
        send_level(1'b1, 60);
        send_level(1'b0, 45);
        send_level(1'b1, 15);
        send_level(1'b0, 85);
        for (int i = 0; i < 21; i++) send_bit_fast(1'b0);
        gap();
        total_cnt++;
        if (pix_q.size() !== 1 || be_cnt !== 0)
            $display("FAIL boundary_count: got n=%0d be=%0d want n=1 be=0", pix_q.size(), be_cnt);
        else pass_cnt++;
        if (pix_q.size() >= 1) begin
            total_cnt++;
            if (pix_q[0] !== 24'h400000)
                $display("FAIL boundary_thresh: got %h want 400000", pix_q[0]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_frame();
        test_partial();
        test_glitch();
        test_stuck();
        test_reset_mid();
        test_boundary();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
